fault_monitor: RTL and testbench
================================

FAULT_MONITOR -- requirements
Module: fault_monitor

Interface
REQ-001 The block SHALL expose parameters: FILL_WINDOW 64, fill check window in cycles; FILL_MIN_RISE 8'd4, minimum level rise per window; TACH_WINDOW 100, motor check window in cycles; TACH_MIN 3, minimum tach edges per window in WASH/RINSE; TACH_MIN_SPIN 6, minimum tach edges per window in SPIN; SENSOR_DELTA 8'd16, allowed level_a/level_b mismatch; PERSIST 8, consecutive mismatch cycles before fault.
REQ-002 Ports SHALL be: clock in 1, sole clock; reset in 1, synchronous active-high.
REQ-003 state in 9, one-hot controller state (IDLE..ERROR encodings as Controller).
REQ-004 water_filling in 1, controller fill valve command.
REQ-005 level_a in 8, primary water level sensor; level_b in 8, redundant level sensor.
REQ-006 motor_tach in 1, asynchronous pulse per drum revolution.
REQ-007 clear_faults in 1, operator fault acknowledge.
REQ-008 sig_Motor_Failure out 1; sig_Low_Water_Pressure out 1; sig_Sensor_Malfunction out 1; each a registered sticky fault flag to Controller.
REQ-009 fault_code out 2, first latched fault: 0 none, 1 sensor, 2 pressure, 3 motor; fault_active out 1, OR of the three flags.

Function
REQ-010 Monitor FSM SHALL have states M_OFF, M_FILL, M_MOTOR; M_FILL when water_filling=1, M_MOTOR when state is WASH, RINSE or SPIN and water_filling=0, else M_OFF; evaluated every cycle.
REQ-011 On entry to M_FILL the block SHALL capture level_a as baseline and clear the window counter.
REQ-012 In M_FILL, when counter reaches FILL_WINDOW-1: if level_a minus baseline (unsigned, level_a<baseline treated as rise 0) < FILL_MIN_RISE, set sig_Low_Water_Pressure next cycle; else re-capture baseline and restart window.
REQ-013 motor_tach SHALL pass through a 2-flop synchronizer then rising-edge detect; edge count saturates at 255.
REQ-014 In M_MOTOR, at counter TACH_WINDOW-1: if edges < threshold (TACH_MIN_SPIN when state=SPIN, else TACH_MIN) set sig_Motor_Failure next cycle; edge count and window then restart.
REQ-015 A change of controller state (e.g. WASH->SPIN) or FSM state SHALL restart the active window and discard partial counts.
REQ-016 In M_OFF window counters SHALL hold at 0; no pressure/motor evaluation.
REQ-017 Sensor check SHALL run in all states: |level_a-level_b| > SENSOR_DELTA for PERSIST consecutive cycles sets sig_Sensor_Malfunction; any in-range cycle resets the persistence count.
REQ-018 Flags SHALL be sticky; evaluations for an already-set flag are ignored.
REQ-019 fault_code SHALL latch only when currently 0; simultaneous new faults resolve sensor > pressure > motor.
REQ-020 clear_faults=1 SHALL clear all flags, fault_code, counters and persistence next cycle; a condition still present re-asserts only after a fresh full window/PERSIST count.
REQ-021 Flags SHALL stay 0 for any input while state=IDLE except sensor check.

Reset
REQ-022 reset=1 at a clock edge SHALL zero all outputs, counters, baseline, synchronizer and edge flops, FSM to M_OFF; reset dominates clear_faults and all detections, including mid-window.

Structure
REQ-023 washer_pkg SHALL hold the nine one-hot state encodings (shared with Controller) and the four fault_code values.
REQ-024 Synchronizer+edge detect SHALL be sub-module tach_edge_detect (in clock, reset, async_in; out rise_pulse).
REQ-025 Parameters SHALL be overridable per instance; counters sized by $clog2 of their window.

Verification
REQ-026 Fill stall: state=FILL, water_filling=1, level_a=level_b=40 constant -> sig_Low_Water_Pressure=1 at cycle 65 after fill entry, fault_code=2.
REQ-027 Good spin: state=SPIN, tach 8 pulses/100 cycles -> no fault over 1000 cycles; switch to 4 pulses/100 -> sig_Motor_Failure=1 at end of next full window, fault_code=3.
REQ-028 Sensor split: level_a=100, level_b=120 for 7 cycles then equal -> no fault; for 8 cycles -> sig_Sensor_Malfunction=1, fault_code=1.
REQ-029 Simultaneous: pressure and sensor faults on same cycle -> both flags 1, fault_code=1; clear_faults pulse -> all 0 next cycle.
REQ-030 Reset mid-window: state=WASH, reset at cycle 50 of window with 0 tach -> no motor fault until 100 cycles after reset release.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared washer definitions: controller state encodings,
// fault codes and monitor FSM states.
package washer_pkg;

    localparam logic [8:0] ST_IDLE  = 9'b0_0000_0001;
    localparam logic [8:0] ST_FILL  = 9'b0_0000_0010;
    localparam logic [8:0] ST_WASH  = 9'b0_0000_0100;
    localparam logic [8:0] ST_DRAIN = 9'b0_0000_1000;
    localparam logic [8:0] ST_RINSE = 9'b0_0001_0000;
    localparam logic [8:0] ST_SPIN  = 9'b0_0010_0000;
    localparam logic [8:0] ST_DONE  = 9'b0_0100_0000;
    localparam logic [8:0] ST_PAUSE = 9'b0_1000_0000;
    localparam logic [8:0] ST_ERROR = 9'b1_0000_0000;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_SENSOR   = 2'd1;
    localparam logic [1:0] FC_PRESSURE = 2'd2;
    localparam logic [1:0] FC_MOTOR    = 2'd3;

    typedef enum logic [1:0] {
        M_OFF,
        M_FILL,
        M_MOTOR
    } mon_state_t;

    function automatic logic [7:0] abs_diff(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/tach_edge_detect.sv
// Two-flop synchronizer for the asynchronous tach input
// followed by a single-cycle rising-edge pulse.
module tach_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_in};
            prev_q <= sync_q[1];
        end
    end

    assign rise_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/fault_monitor.sv
// Washer fault monitor: fill-rate, motor-tach and level-sensor
// plausibility checks with sticky flags and first-fault code.
module fault_monitor
    import washer_pkg::*;
#(
    parameter int unsigned FILL_WINDOW   = 64,
    parameter logic [7:0]  FILL_MIN_RISE = 8'd4,
    parameter int unsigned TACH_WINDOW   = 100,
    parameter logic [7:0]  TACH_MIN      = 8'd3,
    parameter logic [7:0]  TACH_MIN_SPIN = 8'd6,
    parameter logic [7:0]  SENSOR_DELTA  = 8'd16,
    parameter int unsigned PERSIST       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] state,
    input  logic       water_filling,
    input  logic [7:0] level_a,
    input  logic [7:0] level_b,
    input  logic       motor_tach,
    input  logic       clear_faults,
    output logic       sig_Motor_Failure,
    output logic       sig_Low_Water_Pressure,
    output logic       sig_Sensor_Malfunction,
    output logic [1:0] fault_code,
    output logic       fault_active
);

    localparam int FW = (FILL_WINDOW > 1) ? $clog2(FILL_WINDOW) : 1;
    localparam int TW = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;
    localparam int PW = $clog2(PERSIST + 1);

    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_WINDOW - 1);
    localparam logic [TW-1:0] TACH_LAST = TW'(TACH_WINDOW - 1);
    localparam logic [PW-1:0] PERS_LAST = PW'(PERSIST - 1);
    localparam logic [PW-1:0] PERS_MAX  = PW'(PERSIST);

    mon_state_t    mon_q;
    mon_state_t    mon_d;
    logic [8:0]    state_q;
    logic [FW-1:0] fill_cnt_q;
    logic [TW-1:0] tach_cnt_q;
    logic [7:0]    baseline_q;
    logic [7:0]    edges_q;
    logic [PW-1:0] pers_q;
    logic          motor_q;
    logic          press_q;
    logic          sensor_q;
    logic [1:0]    code_q;

    logic       rise;
    logic       motor_st;
    logic       restart;
    logic       fill_end;
    logic       tach_end;
    logic       mismatch;
    logic [7:0] fill_rise;
    logic [7:0] edges_sum;
    logic [7:0] tach_thr;
    logic       set_press;
    logic       set_motor;
    logic       set_sensor;

    tach_edge_detect u_tach (
        .clock      (clock),
        .reset      (reset),
        .async_in   (motor_tach),
        .rise_pulse (rise)
    );

    assign motor_st = (state == ST_WASH)
                   || (state == ST_RINSE)
                   || (state == ST_SPIN);

    // IDLE overrides the valve command so nothing but the
    // sensor check can raise a flag while the washer is idle.
    always_comb begin
        mon_d = M_OFF;
        if (state == ST_IDLE) begin
            mon_d = M_OFF;
        end else if (water_filling) begin
            mon_d = M_FILL;
        end else if (motor_st) begin
            mon_d = M_MOTOR;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mon_q   <= M_OFF;
            state_q <= '0;
        end else begin
            mon_q   <= mon_d;
            state_q <= state;
        end
    end

    assign restart = (mon_d != mon_q) || (state != state_q);

    assign fill_rise = (level_a >= baseline_q)
                     ? level_a - baseline_q : 8'd0;
    assign fill_end  = (fill_cnt_q == FILL_LAST);
    assign tach_end  = (tach_cnt_q == TACH_LAST);
    assign edges_sum = (edges_q == 8'hFF)
                     ? 8'hFF : edges_q + {7'd0, rise};
    assign tach_thr  = (state == ST_SPIN) ? TACH_MIN_SPIN : TACH_MIN;
    assign mismatch  = abs_diff(level_a, level_b) > SENSOR_DELTA;

    assign set_press = !restart && (mon_d == M_FILL) && fill_end
                    && (fill_rise < FILL_MIN_RISE) && !press_q;
    assign set_motor = !restart && (mon_d == M_MOTOR) && tach_end
                    && (edges_sum < tach_thr) && !motor_q;
    assign set_sensor = mismatch && (pers_q == PERS_LAST) && !sensor_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fill_cnt_q <= '0;
            tach_cnt_q <= '0;
            edges_q    <= '0;
            baseline_q <= '0;
        end else if (clear_faults || restart || mon_d == M_OFF) begin
            fill_cnt_q <= '0;
            tach_cnt_q <= '0;
            edges_q    <= '0;
            baseline_q <= level_a;
        end else if (mon_d == M_FILL) begin
            if (fill_end) begin
                fill_cnt_q <= '0;
                if (fill_rise >= FILL_MIN_RISE) begin
                    baseline_q <= level_a;
                end
            end else begin
                fill_cnt_q <= fill_cnt_q + FW'(1);
            end
        end else begin
            if (tach_end) begin
                tach_cnt_q <= '0;
                edges_q    <= '0;
            end else begin
                tach_cnt_q <= tach_cnt_q + TW'(1);
                edges_q    <= edges_sum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pers_q <= '0;
        end else if (clear_faults || !mismatch) begin
            pers_q <= '0;
        end else if (pers_q != PERS_MAX) begin
            pers_q <= pers_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear_faults) begin
            motor_q  <= 1'b0;
            press_q  <= 1'b0;
            sensor_q <= 1'b0;
            code_q   <= FC_NONE;
        end else begin
            if (set_sensor) sensor_q <= 1'b1;
            if (set_press)  press_q  <= 1'b1;
            if (set_motor)  motor_q  <= 1'b1;
            if (code_q == FC_NONE) begin
                if (set_sensor) begin
                    code_q <= FC_SENSOR;
                end else if (set_press) begin
                    code_q <= FC_PRESSURE;
                end else if (set_motor) begin
                    code_q <= FC_MOTOR;
                end
            end
        end
    end

    assign sig_Motor_Failure      = motor_q;
    assign sig_Low_Water_Pressure = press_q;
    assign sig_Sensor_Malfunction = sensor_q;
    assign fault_code             = code_q;
    assign fault_active           = motor_q | press_q | sensor_q;

endmodule

// File: tb/tb_fault_monitor.sv
// Scoreboard bench for fault_monitor: directed scenarios plus
// random phases against a behavioural reference model.
module tb_fault_monitor;
    import washer_pkg::*;

    localparam int FILL_W   = 64;
    localparam int MIN_RISE = 4;
    localparam int TACH_W   = 100;
    localparam int T_MIN    = 3;
    localparam int T_SPIN   = 6;
    localparam int DELTA    = 16;
    localparam int PERS     = 8;

    logic       clk_tb = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] state = ST_IDLE;
    logic       water_filling = 1'b0;
    logic [7:0] level_a = '0;
    logic [7:0] level_b = '0;
    logic       motor_tach = 1'b0;
    logic       clear_faults = 1'b0;
    logic       sig_Motor_Failure;
    logic       sig_Low_Water_Pressure;
    logic       sig_Sensor_Malfunction;
    logic [1:0] fault_code;
    logic       fault_active;

    always #5 clk_tb = ~clk_tb;

    fault_monitor dut (
        .clock                  (clk_tb),
        .reset                  (reset),
        .state                  (state),
        .water_filling          (water_filling),
        .level_a                (level_a),
        .level_b                (level_b),
        .motor_tach             (motor_tach),
        .clear_faults           (clear_faults),
        .sig_Motor_Failure      (sig_Motor_Failure),
        .sig_Low_Water_Pressure (sig_Low_Water_Pressure),
        .sig_Sensor_Malfunction (sig_Sensor_Malfunction),
        .fault_code             (fault_code),
        .fault_active           (fault_active)
    );

    typedef struct packed {
        logic       m;
        logic       p;
        logic       s;
        logic [1:0] code;
        logic       act;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model: mode 0 off, 1 fill, 2 motor
    int         md_prev_mode;
    logic [8:0] md_prev_st;
    int         md_elapsed;
    int         md_pulses;
    int         md_base;
    int         md_run;
    bit         h1, h2, h3;
    bit         f_m, f_p, f_s;
    int         f_code;

    task automatic chk(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t",
                     name, got, exp, $time);
        end
    endtask

    function automatic void model_step(
        input logic [8:0] st, input logic wf,
        input logic [7:0] la, input logic [7:0] lb,
        input logic tach, input logic clr, input logic rst);
        int  a, b, mode, diff, thr;
        bit  pulse, fresh, ns, np, nm;
        a = la;
        b = lb;
        if (rst) begin
            md_prev_mode = 0; md_prev_st = '0;
            md_elapsed = 0; md_pulses = 0; md_base = 0; md_run = 0;
            h1 = 0; h2 = 0; h3 = 0;
            f_m = 0; f_p = 0; f_s = 0; f_code = 0;
            return;
        end
        pulse = h2 && !h3;
        h3 = h2; h2 = h1; h1 = tach;
        if (st == ST_IDLE) mode = 0;
        else if (wf) mode = 1;
        else if (st == ST_WASH || st == ST_RINSE || st == ST_SPIN)
            mode = 2;
        else mode = 0;
        fresh = (mode != md_prev_mode) || (st != md_prev_st);
        md_prev_mode = mode;
        md_prev_st = st;
        diff = (a > b) ? a - b : b - a;
        md_run = (diff > DELTA) ? md_run + 1 : 0;
        if (clr) begin
            f_m = 0; f_p = 0; f_s = 0; f_code = 0;
            md_elapsed = 0; md_pulses = 0; md_base = a; md_run = 0;
            return;
        end
        ns = (md_run == PERS) && !f_s;
        np = 0;
        nm = 0;
        if (fresh || mode == 0) begin
            md_elapsed = 0; md_pulses = 0; md_base = a;
        end else if (mode == 1) begin
            if (md_elapsed == FILL_W - 1) begin
                md_elapsed = 0;
                if (((a >= md_base) ? a - md_base : 0) < MIN_RISE)
                    np = !f_p;
                else
                    md_base = a;
            end else md_elapsed++;
        end else begin
            md_pulses = md_pulses + int'(pulse);
            if (md_pulses > 255) md_pulses = 255;
            if (md_elapsed == TACH_W - 1) begin
                thr = (st == ST_SPIN) ? T_SPIN : T_MIN;
                nm = (md_pulses < thr) && !f_m;
                md_elapsed = 0;
                md_pulses = 0;
            end else md_elapsed++;
        end
        if (f_code == 0)
            f_code = ns ? 1 : np ? 2 : nm ? 3 : 0;
        f_s = f_s | ns;
        f_p = f_p | np;
        f_m = f_m | nm;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.m = f_m;
        o.p = f_p;
        o.s = f_s;
        o.code = f_code[1:0];
        o.act = f_m | f_p | f_s;
        return o;
    endfunction

    task automatic step(input logic [8:0] st, input logic wf,
                        input logic [7:0] la, input logic [7:0] lb,
                        input logic tach, input logic clr,
                        input logic rst);
        @(negedge clk_tb);
        state = st;
        water_filling = wf;
        level_a = la;
        level_b = lb;
        motor_tach = tach;
        clear_faults = clr;
        reset = rst;
        model_step(st, wf, la, lb, tach, clr, rst);
        exp_q.push_back(model_obs());
    endtask

    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk_tb);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = {sig_Motor_Failure, sig_Low_Water_Pressure,
                     sig_Sensor_Malfunction, fault_code, fault_active};
                chk("scoreboard", 8'(g), 8'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] st_tab [9];
        logic [8:0] st;
        logic       wf, tk, clr, rst;
        int         len, per, slope, a, b, off, burst;
        st_tab[0] = ST_IDLE;  st_tab[1] = ST_FILL;
        st_tab[2] = ST_WASH;  st_tab[3] = ST_DRAIN;
        st_tab[4] = ST_RINSE; st_tab[5] = ST_SPIN;
        st_tab[6] = ST_DONE;  st_tab[7] = ST_PAUSE;
        st_tab[8] = ST_ERROR;

        // fill stall
        step(ST_IDLE, 0, 0, 0, 0, 0, 1);
        chk("reset_code", 8'(fault_code), 8'd0);
        for (int n = 0; n <= 66; n++) begin
            step(ST_FILL, 1, 40, 40, 0, 0, 0);
            if (n == 64)
                chk("stall_pre", 8'(sig_Low_Water_Pressure), 8'd0);
            if (n == 65) begin
                chk("stall_set", 8'(sig_Low_Water_Pressure), 8'd1);
                chk("stall_code", 8'(fault_code), 8'd2);
            end
        end

        // good spin then slow spin
        step(ST_IDLE, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 1000; n++)
            step(ST_SPIN, 0, 50, 50, (n % 12) < 2, 0, 0);
        chk("spin_good", 8'(fault_active), 8'd0);
        for (int n = 0; n < 200; n++)
            step(ST_SPIN, 0, 50, 50, (n % 25) < 2, 0, 0);
        chk("spin_slow", 8'(sig_Motor_Failure), 8'd1);
        chk("spin_code", 8'(fault_code), 8'd3);

        // sensor split 7 then 8 cycles
        step(ST_IDLE, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 7; n++) step(ST_IDLE, 0, 100, 120, 0, 0, 0);
        for (int n = 0; n < 5; n++) step(ST_IDLE, 0, 100, 100, 0, 0, 0);
        chk("split7", 8'(sig_Sensor_Malfunction), 8'd0);
        for (int n = 0; n < 8; n++) step(ST_IDLE, 0, 100, 120, 0, 0, 0);
        for (int n = 0; n < 3; n++) step(ST_IDLE, 0, 100, 100, 0, 0, 0);
        chk("split8", 8'(sig_Sensor_Malfunction), 8'd1);
        chk("split8_code", 8'(fault_code), 8'd1);

        // simultaneous sensor + pressure, then clear
        step(ST_IDLE, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n <= 67; n++) begin
            b = (n >= 57 && n <= 64) ? 60 : 40;
            step(ST_FILL, 1, 40, 8'(b), 0, n == 66, 0);
            if (n == 65) begin
                chk("simul_flags", 8'({sig_Motor_Failure,
                    sig_Low_Water_Pressure, sig_Sensor_Malfunction}),
                    8'b011);
                chk("simul_code", 8'(fault_code), 8'd1);
            end
            if (n == 67) begin
                chk("clear_active", 8'(fault_active), 8'd0);
                chk("clear_code", 8'(fault_code), 8'd0);
            end
        end

        // reset mid-window
        step(ST_IDLE, 0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 50; n++) step(ST_WASH, 0, 50, 50, 0, 0, 0);
        step(ST_WASH, 0, 50, 50, 0, 0, 1);
        for (int j = 0; j <= 101; j++) begin
            step(ST_WASH, 0, 50, 50, 0, 0, 0);
            if (j == 100)
                chk("rst_mid_pre", 8'(sig_Motor_Failure), 8'd0);
            if (j == 101)
                chk("rst_mid_set", 8'(sig_Motor_Failure), 8'd1);
        end

        // random phases
        burst = 0;
        a = 0;
        for (int ph = 0; ph < 40; ph++) begin
            st = st_tab[$urandom_range(0, 8)];
            wf = ($urandom_range(0, 2) == 0);
            len = $urandom_range(30, 260);
            per = $urandom_range(3, 40);
            slope = $urandom_range(0, 20);
            a = $urandom_range(0, 200);
            for (int c = 0; c < len; c++) begin
                if (slope != 0 && c % slope == 0) a = (a + 1) & 255;
                if (burst == 0 && $urandom_range(0, 60) == 0)
                    burst = $urandom_range(3, 12);
                if (burst != 0) begin
                    off = $urandom_range(17, 40);
                    burst--;
                end else off = $urandom_range(0, 16);
                b = (a + off > 255) ? a - off : a + off;
                tk = (c % per) < (per + 1) / 2;
                clr = ($urandom_range(0, 150) == 0);
                rst = ($urandom_range(0, 400) == 0);
                step(st, wf, 8'(a), 8'(b), tk, clr, rst);
            end
        end

        @(posedge clk_tb);
        #2;
        if (exp_q.size() != 0)
            chk("queue_drain", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
